// File: rtl/hazard_if.sv
// hazard_if: bundles the pipeline-side signals exchanged with the hazard unit.
//   master : the core pipeline (drives register ids, enables, memory status;
//            receives forward selects, stall/flush controls, mul/div done,
//            stall counter)
//   slave  : the hazard unit itself
interface hazard_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  logic        RegWriteM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic        MulDivStartE;
  logic        MemReqM;
  logic        MemReadyM;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushM;
  logic        FlushW;
  logic        MulDivDoneE;
  logic [31:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulDivStartE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MulDivDoneE, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulDivStartE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MulDivDoneE, StallCount
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard and stall controller for the 5-stage core.
//   clk, rst_n : core clock, synchronous active-low reset
//   hif        : hazard_if slave port
//                inputs  - Decode/Execute source regs, E/M/W dest regs and
//                          write enables, load marker, branch taken,
//                          mul/div start, data-memory request/ready
//                outputs - ForwardAE/BE operand selects, per-stage stall and
//                          flush controls, mul/div done, saturating count of
//                          cycles with StallF high
// Forward/stall/flush outputs are combinational; only the mul/div sequencer
// and the stall counter hold state.
module hazard_unit #(
  parameter int MD_LATENCY = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hif
);

  localparam int              CNT_W    = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t        state_r;
  md_state_t        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [31:0]      stall_count_r;

  logic mem_wait_s;
  logic load_use_s;
  logic md_stall_s;
  logic md_done_s;
  logic stall_f_s;
  logic stall_d_s;
  logic stall_e_s;
  logic stall_m_s;
  logic flush_d_s;
  logic flush_e_s;
  logic flush_m_s;
  logic flush_w_s;

  // Memory-stage producer wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       rw_m,
    input logic [4:0] rd_m,
    input logic       rw_w,
    input logic [4:0] rd_w
  );
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd_sel = 2'b10;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd_sel = 2'b01;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  assign mem_wait_s = hif.MemReqM && !hif.MemReadyM;
  assign load_use_s = (hif.ResultSrcE == 2'b01) && (hif.RdE != 5'd0) &&
                      ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));

  // Mul/div sequencer next-state: the whole sequence is frozen while memory waits.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    md_stall_s  = 1'b0;
    md_done_s   = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (hif.MulDivStartE) begin
          md_stall_s  = 1'b1;
          state_nxt_s = MD_BUSY;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_r != CNT_ZERO) begin
          md_stall_s = 1'b1;
          cnt_nxt_s  = cnt_r - CNT_ONE;
        end else begin
          md_done_s   = 1'b1;
          state_nxt_s = MD_IDLE;
        end
      end
      default: begin
        state_nxt_s = MD_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    // Holding in BUSY with cnt==0 would otherwise report done twice.
    if (mem_wait_s) begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      md_done_s   = 1'b0;
    end else begin
      md_done_s   = md_done_s;
    end
  end

  // Prioritised stall/flush: a lower source never flushes a stage held above it.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_m_s = 1'b0;
    flush_w_s = 1'b0;
    if (mem_wait_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else if (md_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      flush_m_s = 1'b1;
    end else if (load_use_s) begin
      // A concurrent taken branch cannot flush Decode here: Decode is held.
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if (hif.PCSrcE) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end
  end

  // Sequencer state and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= MD_IDLE;
      cnt_r         <= CNT_ZERO;
      stall_count_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (stall_f_s && (stall_count_r != 32'hFFFF_FFFF)) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
    end
  end

  assign hif.ForwardAE   = fwd_sel(hif.Rs1E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
  assign hif.ForwardBE   = fwd_sel(hif.Rs2E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
  assign hif.StallF      = stall_f_s;
  assign hif.StallD      = stall_d_s;
  assign hif.StallE      = stall_e_s;
  assign hif.StallM      = stall_m_s;
  assign hif.FlushD      = flush_d_s;
  assign hif.FlushE      = flush_e_s;
  assign hif.FlushM      = flush_m_s;
  assign hif.FlushW      = flush_w_s;
  assign hif.MulDivDoneE = md_done_s;
  assign hif.StallCount  = stall_count_r;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: self-checking bench for hazard_unit (MD_LATENCY=4).
// Each cycle the expected output bundle is pushed when stimulus is applied and
// popped and compared at the falling edge.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_if hif ();
  hazard_unit #(.MD_LATENCY(4)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));

  // stall = {F,D,E,M}, flush = {D,E,M,W}
  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        done;
    logic [31:0] cnt;
  } obs_t;

  obs_t        obs;
  obs_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_cnt = 32'd0;

  assign obs = {hif.ForwardAE, hif.ForwardBE,
                hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                hif.FlushD, hif.FlushE, hif.FlushM, hif.FlushW,
                hif.MulDivDoneE, hif.StallCount};

  function automatic obs_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] st, input logic [3:0] fl,
                              input logic dn, input logic [31:0] cnt);
    mk = {fa, fb, st, fl, dn, cnt};
  endfunction

  task automatic clear_inputs();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
    hif.RdE = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0;
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.ResultSrcE = 2'b00;
    hif.PCSrcE = 1'b0; hif.MulDivStartE = 1'b0;
    hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [4:0] rs1d, input logic [4:0] rs2d,
                         input logic [4:0] rde, input logic [1:0] rsrc,
                         input logic pcsrc);
    hif.Rs1D = rs1d; hif.Rs2D = rs2d; hif.RdE = rde;
    hif.ResultSrcE = rsrc; hif.PCSrcE = pcsrc;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, exp_cnt));
    @(negedge clk);
    e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL reset: got %h want %h", obs, e); else passed++;
    next_cycle();
  endtask

  task automatic test_forwarding();
    logic [4:0] rs1e [7] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd3, 5'd4, 5'd6};
    logic [4:0] rs2e [7] = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd9, 5'd4, 5'd6};
    logic [4:0] rdm  [7] = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd9, 5'd4, 5'd6};
    logic [4:0] rdw  [7] = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd3, 5'd4, 5'd6};
    logic       rwm  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rww  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] efa  [7] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [1:0] efb  [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
    obs_t e;
    for (int i = 0; i < 7; i++) begin
      hif.Rs1E = rs1e[i]; hif.Rs2E = rs2e[i]; hif.RdM = rdm[i]; hif.RdW = rdw[i];
      hif.RegWriteM = rwm[i]; hif.RegWriteW = rww[i];
      exp_q.push_back(mk(efa[i], efb[i], 4'b0000, 4'b0000, 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL forward[%0d]: got %h want %h", i, obs, e); else passed++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [4:0] rs1d [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd7};
    logic [4:0] rs2d [6] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0};
    logic [4:0] rde  [6] = '{5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 5'd7};
    logic [1:0] rsrc [6] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic [3:0] est  [6] = '{4'b1100, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000};
    logic [3:0] efl  [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    obs_t e;
    for (int i = 0; i < 6; i++) begin
      set_dec(rs1d[i], rs2d[i], rde[i], rsrc[i], 1'b0);
      exp_q.push_back(mk(2'b00, 2'b00, est[i], efl[i], 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL load_use[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    logic       lu  [3] = '{1'b0, 1'b1, 1'b0};
    logic       pc  [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] est [3] = '{4'b0000, 4'b1100, 4'b0000};
    logic [3:0] efl [3] = '{4'b1100, 4'b0100, 4'b0000};
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      if (lu[i]) set_dec(5'd0, 5'd7, 5'd7, 2'b01, pc[i]);
      else       set_dec(5'd0, 5'd0, 5'd0, 2'b00, pc[i]);
      exp_q.push_back(mk(2'b00, 2'b00, est[i], efl[i], 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL branch[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    logic       req [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       oth [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] est [4] = '{4'b1111, 4'b1111, 4'b1100, 4'b0000};
    logic [3:0] efl [4] = '{4'b0001, 4'b0001, 4'b0100, 4'b0000};
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      hif.MemReqM = req[i]; hif.MemReadyM = rdy[i];
      if (oth[i]) set_dec(5'd0, 5'd7, 5'd7, 2'b01, 1'b1);
      else        set_dec(5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      exp_q.push_back(mk(2'b00, 2'b00, est[i], efl[i], 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL mem_wait[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  // Start at i=0 with MD_LATENCY=4: stalls 0..2, done at 3, idle at 4.
  task automatic test_muldiv();
    obs_t e;
    for (int i = 0; i < 5; i++) begin
      hif.MulDivStartE = (i < 4);
      if (i < 3)       exp_q.push_back(mk(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0, exp_cnt));
      else if (i == 3) exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b1, exp_cnt));
      else             exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL muldiv[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  // Memory wait at t+1, t+2 pushes done from t+3 to t+5.
  task automatic test_muldiv_mem_wait();
    obs_t e;
    for (int i = 0; i < 7; i++) begin
      hif.MulDivStartE = (i < 6);
      hif.MemReqM = (i == 1) || (i == 2);
      hif.MemReadyM = 1'b0;
      if (i == 1 || i == 2)      exp_q.push_back(mk(2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, exp_cnt));
      else if (i == 5)           exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b1, exp_cnt));
      else if (i == 6)           exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, exp_cnt));
      else                       exp_q.push_back(mk(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL muldiv_wait[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  // Two mul/divs back to back: second starts the cycle after the first is done.
  task automatic test_back_to_back();
    obs_t e;
    for (int i = 0; i < 9; i++) begin
      hif.MulDivStartE = (i < 8);
      if (i == 3 || i == 7) exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b1, exp_cnt));
      else if (i == 8)      exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, exp_cnt));
      else                  exp_q.push_back(mk(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  // Reset sampled at the end of t+1 aborts the mul/div and clears the counter.
  task automatic test_reset_abort();
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      hif.MulDivStartE = (i < 2);
      rst_n = (i == 1) ? 1'b0 : 1'b1;
      if (i < 2) exp_q.push_back(mk(2'b00, 2'b00, 4'b1110, 4'b0010, 1'b0, exp_cnt));
      else       exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL reset_abort[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3]) exp_cnt = exp_cnt + 32'd1;
      if (i == 1) exp_cnt = 32'd0;
      next_cycle();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_saturation();
    obs_t e;
    force dut.stall_count_r = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count_r;
    exp_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_dec(5'd7, 5'd0, 5'd7, 2'b01, 1'b0);
      else       set_dec(5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      if (i < 4) exp_q.push_back(mk(2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0, exp_cnt));
      else       exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, exp_cnt));
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL saturate[%0d]: got %h want %h", i, obs, e); else passed++;
      if (e.stall[3] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_muldiv();
    test_muldiv_mem_wait();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net: the run is a fixed number of cycles, so this never fires normally.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
